bamse_intc: RTL and testbench

- Interrupt controller between up to 8 peripheral interrupt lines and the single Pacoblaze interrupt/interrupt_ack pair.
- Peripheral lines include io_bamse interrupt, timer and uart.
- Latches rising edges into a pending register and applies a mask.
- Arbitrates by fixed or round-robin priority, drives the CPU interrupt, exposes the serviced source as a vector on the Pacoblaze port bus.

---
 rtl/bamse_pkg.sv | 27 ++
 rtl/bamse_intc_prio.sv | 50 +++++
 rtl/bamse_intc.sv | 203 ++++++++++++++++++++
 tb/tb_bamse_intc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bamse_pkg.sv
// -----------------------------------------------------------------------------
// bamse_pkg
//   Shared definitions for the bamse interrupt controller slice.
//   - Register offsets (relative to the controller's BASE_ADDR).
//   - CTRL register bit positions.
//   - Controller FSM state encoding.
// -----------------------------------------------------------------------------
package bamse_pkg;

   // Register offsets within the 4-entry controller window
   localparam logic [1:0] INTC_CTRL = 2'd0;
   localparam logic [1:0] INTC_MASK = 2'd1;
   localparam logic [1:0] INTC_PEND = 2'd2;
   localparam logic [1:0] INTC_VEC  = 2'd3;

   // CTRL register bit positions
   localparam int unsigned CTRL_GIE = 0;   // global interrupt enable
   localparam int unsigned CTRL_RR  = 1;   // round-robin arbitration enable

   // Controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } intc_state_t;

endpackage

// File: rtl/bamse_intc_prio.sv
// -----------------------------------------------------------------------------
// bamse_intc_prio
//   Combinational priority picker for the interrupt controller.
//   Fixed mode (i_rr=0): lowest set index of i_req wins.
//   Round-robin mode (i_rr=1): search begins at i_start and wraps modulo
//   NUM_SRC; the first set index found wins.
//
// Ports:
//   i_req   [NUM_SRC-1:0]  candidate request vector
//   i_start [2:0]          first index searched in round-robin mode (< NUM_SRC)
//   i_rr                   1 = round-robin, 0 = fixed lowest-index priority
//   o_idx   [2:0]          winning index (0 when o_any=0)
//   o_any                  at least one request is set
// -----------------------------------------------------------------------------
module bamse_intc_prio #(
   parameter int unsigned NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [2:0]         i_start,
   input  logic               i_rr,
   output logic [2:0]         o_idx,
   output logic               o_any
);

   localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

   logic [2:0] w_base;

   assign w_base = i_rr ? i_start : 3'd0;

   // Rotating scan: position k of the search maps to index (base+k) mod NUM_SRC.
   // Bit tests use a shifted one-hot so no variable index is wider than needed.
   always_comb begin
      int unsigned j;
      j     = 0;
      o_idx = '0;
      o_any = 1'b0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         j = 32'(w_base) + k;
         if (j >= NUM_SRC) begin
            j = j - NUM_SRC;
         end
         if (!o_any && (|(i_req & (ONE << j)))) begin
            o_any = 1'b1;
            o_idx = 3'(j);
         end
      end
   end

endmodule

// File: rtl/bamse_intc.sv
// -----------------------------------------------------------------------------
// bamse_intc
//   Interrupt controller between up to 8 peripheral interrupt lines and the
//   Pacoblaze interrupt / interrupt_ack pair. Rising edges on irq_src are
//   latched into PENDING, qualified by MASK, arbitrated (fixed or round-robin)
//   and presented to the CPU; the serviced source is exposed in VECTOR until
//   software writes VECTOR (end of interrupt).
//
//   Register map (port_id = BASE_ADDR + offset):
//     +0 CTRL    rw  bit0 GIE, bit1 RR
//     +1 MASK    rw  bit i enables source i
//     +2 PENDING r / write-1-to-clear
//     +3 VECTOR  r {valid, 4'b0, idx[2:0]}; any write = EOI
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   irq_src        peripheral interrupt lines (active-high, synchronous)
//   port_id        Pacoblaze port address
//   port_in        Pacoblaze write data
//   wen            Pacoblaze write strobe
//   port_out       combinational read data (8'h00 outside the map)
//   interrupt      interrupt request to Pacoblaze (registered)
//   interrupt_ack  one-cycle acknowledge from Pacoblaze
// -----------------------------------------------------------------------------
module bamse_intc
   import bamse_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 4,
   parameter logic [7:0]  BASE_ADDR = 8'h10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [7:0]         port_id,
   input  logic [7:0]         port_in,
   input  logic               wen,
   output logic [7:0]         port_out,
   output logic               interrupt,
   input  logic               interrupt_ack
);

   localparam logic [NUM_SRC-1:0] ONE     = NUM_SRC'(1);
   localparam logic [2:0]         LAST_IX = 3'(NUM_SRC - 1);

   // Architectural state
   intc_state_t        r_state;
   logic               r_gie;
   logic               r_rr;
   logic [NUM_SRC-1:0] r_mask;
   logic [NUM_SRC-1:0] r_pend;
   logic [NUM_SRC-1:0] r_prev;
   logic [2:0]         r_sel_idx;
   logic [2:0]         r_last_idx;
   logic               r_vec_valid;
   logic [2:0]         r_vec_idx;
   logic               r_irq;

   // Decode
   logic [7:0]         w_off;
   logic               w_hit;
   logic [1:0]         w_reg;
   logic               w_wr_ctrl;
   logic               w_wr_mask;
   logic               w_wr_pend;
   logic               w_wr_vec;

   // Pending / arbitration
   logic [NUM_SRC-1:0] w_rise;
   logic [NUM_SRC-1:0] w_w1c;
   logic [NUM_SRC-1:0] w_sel_oh;
   logic               w_ack;
   logic [NUM_SRC-1:0] w_ack_clr;
   logic [NUM_SRC-1:0] w_pend_nxt;
   logic [NUM_SRC-1:0] w_req;
   logic               w_sel_live;
   logic [2:0]         w_start;
   logic [2:0]         w_win_idx;
   logic               w_win_any;

   // ---------------------------------------------------------------- decode
   // Offset by subtraction so BASE_ADDR need not be 4-aligned.
   assign w_off     = port_id - BASE_ADDR;
   assign w_hit     = (w_off[7:2] == 6'd0);
   assign w_reg     = w_off[1:0];
   assign w_wr_ctrl = wen && w_hit && (w_reg == INTC_CTRL);
   assign w_wr_mask = wen && w_hit && (w_reg == INTC_MASK);
   assign w_wr_pend = wen && w_hit && (w_reg == INTC_PEND);
   assign w_wr_vec  = wen && w_hit && (w_reg == INTC_VEC);

   // ------------------------------------------------------------- read mux
   always_comb begin
      port_out = '0;
      if (w_hit) begin
         case (w_reg)
            INTC_CTRL: begin
               port_out[CTRL_GIE] = r_gie;
               port_out[CTRL_RR]  = r_rr;
            end
            INTC_MASK: port_out[NUM_SRC-1:0] = r_mask;
            INTC_PEND: port_out[NUM_SRC-1:0] = r_pend;
            default:   port_out = {r_vec_valid, 4'b0000, r_vec_idx};
         endcase
      end
   end

   // ------------------------------------------------------ pending update
   // New edges are OR-ed in last so a same-cycle set beats both the
   // software W1C clear and the acknowledge clear.
   assign w_rise     = irq_src & ~r_prev;
   assign w_w1c      = w_wr_pend ? port_in[NUM_SRC-1:0] : '0;
   assign w_sel_oh   = ONE << r_sel_idx;
   assign w_ack      = (r_state == ST_ASSERT) && interrupt_ack;
   assign w_ack_clr  = w_ack ? w_sel_oh : '0;
   assign w_pend_nxt = (r_pend & ~w_w1c & ~w_ack_clr) | w_rise;

   assign w_req      = r_pend & r_mask;
   assign w_sel_live = |(w_req & w_sel_oh);

   // Round-robin search begins one past the last serviced source.
   assign w_start    = (r_last_idx >= LAST_IX) ? 3'd0 : (r_last_idx + 3'd1);

   bamse_intc_prio #(
      .NUM_SRC (NUM_SRC)
   ) u_prio (
      .i_req   (w_req),
      .i_start (w_start),
      .i_rr    (r_rr),
      .o_idx   (w_win_idx),
      .o_any   (w_win_any)
   );

   // ------------------------------------------------------ register file
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gie  <= 1'b0;
         r_rr   <= 1'b0;
         r_mask <= '0;
         r_pend <= '0;
         r_prev <= '0;
      end else begin
         r_prev <= irq_src;
         r_pend <= w_pend_nxt;
         if (w_wr_ctrl) begin
            r_gie <= port_in[CTRL_GIE];
            r_rr  <= port_in[CTRL_RR];
         end
         if (w_wr_mask) begin
            r_mask <= port_in[NUM_SRC-1:0];
         end
      end
   end

   // ------------------------------------------------------------------ FSM
   // Winner is latched on entry to ASSERT and held, so a later higher-priority
   // arrival never changes the source being offered to the CPU.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_irq       <= 1'b0;
         r_sel_idx   <= '0;
         r_last_idx  <= '0;
         r_vec_valid <= 1'b0;
         r_vec_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_gie && w_win_any) begin
                  r_sel_idx <= w_win_idx;
                  r_irq     <= 1'b1;
                  r_state   <= ST_ASSERT;
               end
            end
            ST_ASSERT: begin
               if (interrupt_ack) begin
                  r_vec_valid <= 1'b1;
                  r_vec_idx   <= r_sel_idx;
                  r_last_idx  <= r_sel_idx;
                  r_irq       <= 1'b0;
                  r_state     <= ST_SERVICE;
               end else if (!w_sel_live || !r_gie) begin
                  r_irq   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_SERVICE: begin
               if (w_wr_vec) begin
                  r_vec_valid <= 1'b0;
                  r_vec_idx   <= '0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_irq   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign interrupt = r_irq;

endmodule

// File: tb/tb_bamse_intc.sv
// -----------------------------------------------------------------------------
// tb_bamse_intc
//   Directed self-checking bench for bamse_intc (NUM_SRC=4, BASE_ADDR=8'h10).
//   Inputs are driven 1 ns after the rising edge; reads sample port_out 1 ns
//   after setting port_id, before the next rising edge.
// -----------------------------------------------------------------------------
module tb_bamse_intc;

   localparam logic [7:0] A_CTRL = 8'h10;
   localparam logic [7:0] A_MASK = 8'h11;
   localparam logic [7:0] A_PEND = 8'h12;
   localparam logic [7:0] A_VEC  = 8'h13;

   logic       clk;
   logic       rst;
   logic [3:0] irq_src;
   logic [7:0] port_id;
   logic [7:0] port_in;
   logic       wen;
   logic [7:0] port_out;
   logic       interrupt;
   logic       interrupt_ack;

   int unsigned n_checks;
   int unsigned n_errors;
   logic [7:0]  rd_data;
   logic [7:0]  rr_exp [4];

   bamse_intc #(
      .NUM_SRC   (4),
      .BASE_ADDR (8'h10)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .irq_src       (irq_src),
      .port_id       (port_id),
      .port_in       (port_in),
      .wen           (wen),
      .port_out      (port_out),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      port_id = addr;
      port_in = data;
      wen     = 1'b1;
      tick();
      wen     = 1'b0;
      port_in = 8'h00;
   endtask

   task automatic rd(input logic [7:0] addr, output logic [7:0] data);
      port_id = addr;
      #1;
      data = port_out;
   endtask

   task automatic pulse(input logic [3:0] v);
      irq_src = v;
      tick();
      irq_src = 4'b0000;
   endtask

   task automatic ack();
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
   endtask

   task automatic quiesce();
      wr(A_MASK, 8'h00);
      wr(A_VEC,  8'h00);
      wr(A_PEND, 8'hFF);
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b0;
      irq_src       = '0;
      port_id       = 8'h00;
      port_in       = 8'h00;
      wen           = 1'b0;
      interrupt_ack = 1'b0;
      rr_exp[0] = 8'h80; rr_exp[1] = 8'h81; rr_exp[2] = 8'h80; rr_exp[3] = 8'h81;

      tick(); tick();
      rst = 1'b1;
      tick();

      // Reset values and register readback masking
      check("rst_int", {7'b0, interrupt}, 8'h00);
      rd(A_CTRL, rd_data); check("rst_ctrl", rd_data, 8'h00);
      rd(A_MASK, rd_data); check("rst_mask", rd_data, 8'h00);
      rd(A_PEND, rd_data); check("rst_pend", rd_data, 8'h00);
      rd(A_VEC,  rd_data); check("rst_vec",  rd_data, 8'h00);
      wr(A_CTRL, 8'hFF); rd(A_CTRL, rd_data); check("ctrl_bits", rd_data, 8'h03);
      wr(A_MASK, 8'hFF); rd(A_MASK, rd_data); check("mask_bits", rd_data, 8'h0F);

      // Fixed priority
      wr(A_CTRL, 8'h01);
      wr(A_MASK, 8'h0F);
      pulse(4'b1010);
      check("fx_lat", {7'b0, interrupt}, 8'h00);
      tick();
      check("fx_int", {7'b0, interrupt}, 8'h01);
      ack();
      check("fx_int_ack", {7'b0, interrupt}, 8'h00);
      rd(A_VEC,  rd_data); check("fx_vec1",  rd_data, 8'h81);
      rd(A_PEND, rd_data); check("fx_pend1", rd_data, 8'h08);
      wr(A_VEC, 8'h00);
      tick();
      check("fx_int2", {7'b0, interrupt}, 8'h01);
      ack();
      rd(A_VEC,  rd_data); check("fx_vec2",  rd_data, 8'h83);
      rd(A_PEND, rd_data); check("fx_pend2", rd_data, 8'h00);

      // Round-robin: edges on sources 0 and 1 arrive during each service
      wr(A_CTRL, 8'h03);
      for (int i = 0; i < 4; i++) begin
         pulse(4'b0011);
         wr(A_VEC, 8'h00);
         tick();
         check("rr_int", {7'b0, interrupt}, 8'h01);
         ack();
         rd(A_VEC, rd_data); check("rr_vec", rd_data, rr_exp[i]);
      end
      // Wrap: service source 3, then 0 and 3 pending -> 0 next
      wr(A_PEND, 8'h0F);
      pulse(4'b1000);
      wr(A_VEC, 8'h00);
      tick();
      ack();
      rd(A_VEC, rd_data); check("rr_vec3", rd_data, 8'h83);
      pulse(4'b1001);
      wr(A_VEC, 8'h00);
      tick();
      check("rr_wrap_int", {7'b0, interrupt}, 8'h01);
      ack();
      rd(A_VEC, rd_data); check("rr_wrap_vec", rd_data, 8'h80);
      quiesce();

      // Withdrawal by masking before ack
      wr(A_CTRL, 8'h01);
      wr(A_MASK, 8'h04);
      pulse(4'b0100);
      tick();
      check("wd_int", {7'b0, interrupt}, 8'h01);
      wr(A_MASK, 8'h00);
      tick();
      check("wd_int_fall", {7'b0, interrupt}, 8'h00);
      rd(A_VEC,  rd_data); check("wd_vec",  rd_data, 8'h00);
      rd(A_PEND, rd_data); check("wd_pend", rd_data, 8'h04);
      ack();
      rd(A_VEC,  rd_data); check("wd_ack_ign_vec",  rd_data, 8'h00);
      rd(A_PEND, rd_data); check("wd_ack_ign_pend", rd_data, 8'h04);
      quiesce();

      // W1C colliding with a new edge on the same source
      irq_src = 4'b0001;
      wr(A_PEND, 8'h01);
      rd(A_PEND, rd_data); check("w1c_set_wins", rd_data, 8'h01);
      wr(A_PEND, 8'h01);
      rd(A_PEND, rd_data); check("w1c_clear", rd_data, 8'h00);
      tick();
      rd(A_PEND, rd_data); check("level_no_edge", rd_data, 8'h00);
      irq_src = 4'b0000;

      // Edge on the active source during SERVICE re-interrupts after EOI
      wr(A_MASK, 8'h01);
      pulse(4'b0001);
      tick();
      check("re_int1", {7'b0, interrupt}, 8'h01);
      ack();
      rd(A_VEC, rd_data); check("re_vec", rd_data, 8'h80);
      pulse(4'b0001);
      check("re_svc_int", {7'b0, interrupt}, 8'h00);
      rd(A_PEND, rd_data); check("re_svc_pend", rd_data, 8'h01);
      wr(A_VEC, 8'h00);
      check("re_eoi_int", {7'b0, interrupt}, 8'h00);
      tick();
      check("re_int2", {7'b0, interrupt}, 8'h01);
      quiesce();

      // GIE gating and unmapped addresses
      wr(A_CTRL, 8'h00);
      wr(A_MASK, 8'h01);
      pulse(4'b0001);
      tick(); tick();
      check("gie_off_int", {7'b0, interrupt}, 8'h00);
      wr(A_CTRL, 8'h01);
      tick();
      check("gie_on_int", {7'b0, interrupt}, 8'h01);
      rd(8'h20, rd_data); check("unmap_20", rd_data, 8'h00);
      rd(8'h14, rd_data); check("unmap_14", rd_data, 8'h00);
      wr(8'h20, 8'hFF);
      rd(A_CTRL, rd_data); check("unmap_wr_ctrl", rd_data, 8'h01);
      rd(A_MASK, rd_data); check("unmap_wr_mask", rd_data, 8'h01);
      rd(A_PEND, rd_data); check("unmap_wr_pend", rd_data, 8'h01);

      // Reset during SERVICE with pending 4'b0110
      wr(A_MASK, 8'h0F);
      ack();
      pulse(4'b0110);
      rd(A_PEND, rd_data); check("pre_rst_pend", rd_data, 8'h06);
      rd(A_VEC,  rd_data); check("pre_rst_vec",  rd_data, 8'h80);
      rst = 1'b0;
      #1;
      check("in_rst_int", {7'b0, interrupt}, 8'h00);
      rd(A_PEND, rd_data); check("in_rst_pend", rd_data, 8'h00);
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_int", {7'b0, interrupt}, 8'h00);
      rd(A_PEND, rd_data); check("post_rst_pend", rd_data, 8'h00);
      rd(A_VEC,  rd_data); check("post_rst_vec",  rd_data, 8'h00);
      rd(A_CTRL, rd_data); check("post_rst_ctrl", rd_data, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
